reg_file: RTL and testbench



---
 rtl/reg_file_pkg.sv | 10 +
 rtl/reg_file_read_port.sv | 38 +++
 rtl/reg_file.sv | 55 +++++
 tb/tb_reg_file.sv | 139 +++++++++++++
 4 files changed

// File: rtl/reg_file_pkg.sv
// Shared constants and types for the 32 x 16 two-read/one-write register file.
package reg_file_pkg;
    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int ZERO_REG = 0;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;
endpackage

// File: rtl/reg_file_read_port.sv
// One combinational read port: 32:1 mux, r0 forced to zero, optional write-through
// forwarding when REG_FILE_BYPASS_EN is defined.
module reg_file_read_port #(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic [2**ADDR_W-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]                rd_addr,
`ifdef REG_FILE_BYPASS_EN
    input  logic                             rst,
    input  logic                             wr_en,
    input  logic [ADDR_W-1:0]                wr_dest,
    input  logic [DATA_W-1:0]                wr_data,
`endif
    output logic [DATA_W-1:0]                rd_data
);
    import reg_file_pkg::*;

    logic is_zero;
    assign is_zero = (rd_addr == ADDR_W'(ZERO_REG));

`ifdef REG_FILE_BYPASS_EN
    // Forward only writes that will actually commit on the coming edge.
    logic fwd;
    assign fwd = rst && wr_en && (wr_dest == rd_addr) && !is_zero;

    always_comb begin
        rd_data = regs[rd_addr];
        if (is_zero)  rd_data = '0;
        else if (fwd) rd_data = wr_data;
    end
`else
    always_comb begin
        rd_data = regs[rd_addr];
        if (is_zero) rd_data = '0;
    end
`endif
endmodule

// File: rtl/reg_file.sv
// Two-read/one-write register file, r0 hardwired to zero, async active-low reset.
// Optional write-through forwarding on the read ports: define REG_FILE_BYPASS_EN.
module reg_file #(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              reg_write_en,
    input  logic [ADDR_W-1:0] reg_write_dest,
    input  logic [DATA_W-1:0] reg_write_data,
    input  logic [ADDR_W-1:0] reg_read_addr_1,
    output logic [DATA_W-1:0] reg_read_data_1,
    input  logic [ADDR_W-1:0] reg_read_addr_2,
    output logic [DATA_W-1:0] reg_read_data_2
);
    import reg_file_pkg::*;

    localparam int N_ENT  = 2 ** ADDR_W;
    localparam int N_PORT = 2;

    logic [N_ENT-1:0][DATA_W-1:0]  regs;
    logic [N_PORT-1:0][ADDR_W-1:0] rd_addr;
    logic [N_PORT-1:0][DATA_W-1:0] rd_data;

    // Entry 0 is never written, so it stays at its reset value of zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            regs <= '0;
        else if (reg_write_en && reg_write_dest != ADDR_W'(ZERO_REG))
            regs[reg_write_dest] <= reg_write_data;
    end

    assign rd_addr[0]      = reg_read_addr_1;
    assign rd_addr[1]      = reg_read_addr_2;
    assign reg_read_data_1 = rd_data[0];
    assign reg_read_data_2 = rd_data[1];

    for (genvar p = 0; p < N_PORT; p++) begin : g_rd
        reg_file_read_port #(
            .DATA_W (DATA_W),
            .ADDR_W (ADDR_W)
        ) u_port (
            .regs    (regs),
            .rd_addr (rd_addr[p]),
`ifdef REG_FILE_BYPASS_EN
            .rst     (rst),
            .wr_en   (reg_write_en),
            .wr_dest (reg_write_dest),
            .wr_data (reg_write_data),
`endif
            .rd_data (rd_data[p])
        );
    end
endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed cases plus randomized traffic against an array model.
module tb_reg_file;
    import reg_file_pkg::*;

    logic      clk = 1'b0;
    logic      rst;
    logic      we;
    reg_addr_t dest, ra1, ra2;
    reg_data_t wdata, rd1, rd2;

    int n_checks = 0;
    int n_errors = 0;
    reg_data_t ref_mem [NUM_REGS];

    always #5 clk = ~clk;

    reg_file dut (
        .clk             (clk),
        .rst             (rst),
        .reg_write_en    (we),
        .reg_write_dest  (dest),
        .reg_write_data  (wdata),
        .reg_read_addr_1 (ra1),
        .reg_read_data_1 (rd1),
        .reg_read_addr_2 (ra2),
        .reg_read_data_2 (rd2)
    );

    task automatic check(input string tag, input reg_data_t got, input reg_data_t exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic reg_data_t model_read(input reg_addr_t a);
        if (a == 0 || !rst) return '0;
`ifdef REG_FILE_BYPASS_EN
        if (we && dest == a) return wdata;
`endif
        return ref_mem[a];
    endfunction

    task automatic check_reads(input string tag);
        check({tag, "_p1"}, rd1, model_read(ra1));
        check({tag, "_p2"}, rd2, model_read(ra2));
    endtask

    task automatic model_clear();
        for (int i = 0; i < NUM_REGS; i++) ref_mem[i] = '0;
    endtask

    // Drive one cycle: check pre-edge reads, take the edge, update model, check post-edge.
    task automatic cyc(input logic w, input reg_addr_t d, input reg_data_t v,
                       input reg_addr_t a1, input reg_addr_t a2, input string tag);
        we = w; dest = d; wdata = v; ra1 = a1; ra2 = a2;
        #1 check_reads({tag, "_pre"});
        @(posedge clk);
        if (rst && w && d != 0) ref_mem[d] = v;
        #1 check_reads({tag, "_post"});
    endtask

    initial begin
        model_clear();
        rst = 1'b0; we = 1'b0; dest = '0; wdata = '0; ra1 = 5'd5; ra2 = 5'd31;
        #2 check("rst_p1", rd1, 16'h0000);
        check("rst_p2", rd2, 16'h0000);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        // Write/read on consecutive edges
        cyc(1'b1, 5'd3,  16'h1234, 5'd3, 5'd31, "wr3");
        cyc(1'b1, 5'd31, 16'hA5A5, 5'd3, 5'd31, "wr31");
        cyc(1'b0, 5'd0,  16'h0000, 5'd3, 5'd31, "rd3_31");
        check("r3_val",  rd1, 16'h1234);
        check("r31_val", rd2, 16'hA5A5);

        // r0 discards writes
        cyc(1'b1, 5'd0, 16'hFFFF, 5'd0, 5'd0, "wr0");
        check("r0_p1", rd1, 16'h0000);
        check("r0_p2", rd2, 16'h0000);

        // Write enable gating
        cyc(1'b1, 5'd7, 16'h0001, 5'd7, 5'd7, "wr7");
        cyc(1'b0, 5'd7, 16'h5555, 5'd7, 5'd7, "we0_7");
        check("r7_hold", rd1, 16'h0001);

        // Same-cycle read/write to r9
        cyc(1'b1, 5'd9, 16'h0010, 5'd9, 5'd9, "wr9a");
        we = 1'b1; dest = 5'd9; wdata = 16'h0020; ra1 = 5'd9; ra2 = 5'd9;
        #1;
`ifdef REG_FILE_BYPASS_EN
        check("r9_pre", rd1, 16'h0020);
`else
        check("r9_pre", rd1, 16'h0010);
`endif
        @(posedge clk); ref_mem[9] = 16'h0020;
        #1 check("r9_post", rd1, 16'h0020);

        // Dual read of the same address
        cyc(1'b1, 5'd12, 16'hC0DE, 5'd12, 5'd12, "wr12");
        check("r12_p1", rd1, 16'hC0DE);
        check("r12_p2", rd2, 16'hC0DE);

        // Async reset mid-cycle after writing r5, with a write presented during reset
        cyc(1'b1, 5'd5, 16'hBEEF, 5'd5, 5'd3, "wr5");
        check("r5_val", rd1, 16'hBEEF);
        we = 1'b1; dest = 5'd5; wdata = 16'h1111;
        #2 rst = 1'b0;
        model_clear();
        #1 check("arst_r5", rd1, 16'h0000);
        check("arst_r3", rd2, 16'h0000);
        @(posedge clk);
        #1 check("arst_hold_r5", rd1, 16'h0000);
        check_reads("arst_hold");
        we = 1'b0;
        #2 rst = 1'b1;
        cyc(1'b0, 5'd0, 16'h0000, 5'd5, 5'd12, "post_rst");

        // Randomized traffic with occasional async reset pulses
        for (int i = 0; i < 400; i++) begin
            reg_addr_t d, a1, a2;
            d  = reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            a1 = ($urandom_range(0, 3) == 0) ? d : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            a2 = ($urandom_range(0, 3) == 0) ? d : reg_addr_t'($urandom_range(0, NUM_REGS - 1));
            if ($urandom_range(0, 49) == 0) begin
                #2 rst = 1'b0;
                model_clear();
                #1 check_reads("rnd_arst");
                #1 rst = 1'b1;
            end
            cyc(1'($urandom_range(0, 1)), d, reg_data_t'($urandom), a1, a2, "rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
